// File: rtl/timestamp_pkg.sv
// Shared definitions for the timestamp framer: frame constants, the buffered
// sample record layout, the output FSM states and the byte selector used to
// serialise a record into a frame.
package timestamp_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 8;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] ts;
    logic [15:0] data;
  } record_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Byte idx of the frame built from rec: sync, flags, ts MSB..LSB, data MSB..LSB
  function automatic logic [7:0] frame_byte(input record_t rec, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = rec.flags;
      3'd2:    b = rec.ts[31:24];
      3'd3:    b = rec.ts[23:16];
      3'd4:    b = rec.ts[15:8];
      3'd5:    b = rec.ts[7:0];
      3'd6:    b = rec.data[15:8];
      default: b = rec.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous record FIFO. Full/empty come from the registered occupancy, so a
// push arriving while full is refused even if a pop happens in the same cycle.
// The head record is presented combinationally on rd_data.
module frame_fifo import timestamp_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_128M,
  input  logic                     rst_n,
  input  logic                     push,
  input  record_t                  wr_data,
  input  logic                     pop,
  output record_t                  rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  record_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy guards every read
  always_ff @(posedge clk_128M) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/timestamp_framer.sv
// Captures timestamped samples into a small record FIFO and streams each
// record to the host as an 8-byte frame over a valid/ready byte interface.
// Dropped samples are counted and flagged on the next accepted record.
module timestamp_framer import timestamp_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_128M,
  input  logic         rst_n,
  input  logic [31:0]  timestamp_count,
  input  logic         offset_adjust,
  input  logic [15:0]  sample_data,
  input  logic         sample_valid,
  output logic [7:0]   m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [15:0]  drop_count
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  record_t                     in_rec;
  record_t                     fifo_head;
  record_t                     frame_rec;
  logic                        push;
  logic                        pop;
  logic                        drop;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] occupancy;
  logic                        occupancy_unused;
  logic                        adjust_flag;
  logic                        overflow_flag;
  logic                        beat;
  state_t                      state;
  logic [2:0]                  byte_idx;

  assign push             = sample_valid && !full;
  assign drop             = sample_valid && full;
  assign beat             = m_tvalid && m_tready;
  assign pop              = !empty && ((state == IDLE) || (beat && byte_idx == LAST_IDX));
  assign occupancy_unused = ^occupancy;

  assign in_rec.flags = {6'b0, overflow_flag, adjust_flag | offset_adjust};
  assign in_rec.ts    = timestamp_count;
  assign in_rec.data  = sample_data;

  frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_128M  (clk_128M),
    .rst_n     (rst_n),
    .push      (push),
    .wr_data   (in_rec),
    .pop       (pop),
    .rd_data   (fifo_head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // Sticky flags ride on the next accepted record and clear there; drops are counted with saturation
  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      adjust_flag   <= 1'b0;
      overflow_flag <= 1'b0;
      drop_count    <= '0;
    end else begin
      if (push) begin
        adjust_flag   <= 1'b0;
        overflow_flag <= 1'b0;
      end else begin
        if (offset_adjust) adjust_flag   <= 1'b1;
        if (drop)          overflow_flag <= 1'b1;
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Output FSM: loads a record into the frame register and walks its bytes on each accepted beat
  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_idx  <= '0;
      frame_rec <= '0;
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            frame_rec <= fifo_head;
            byte_idx  <= '0;
            m_tdata   <= SYNC_BYTE;
            m_tvalid  <= 1'b1;
            m_tlast   <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            if (byte_idx == LAST_IDX) begin
              if (!empty) begin
                frame_rec <= fifo_head;
                byte_idx  <= '0;
                m_tdata   <= SYNC_BYTE;
                m_tlast   <= 1'b0;
              end else begin
                m_tdata  <= 8'h00;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
              m_tdata  <= frame_byte(frame_rec, byte_idx + 3'd1);
              m_tlast  <= ((byte_idx + 3'd1) == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timestamp_framer.sv
// Self-checking bench for timestamp_framer: a record-queue model of the
// framer is compared against the DUT every cycle, and directed scenarios pin
// hand-computed byte streams, flags, drop counts and latency.
module tb_timestamp_framer;

  localparam int DEPTH = 4;

  logic        clk_128M = 1'b0;
  logic        rst_n;
  logic [31:0] timestamp_count;
  logic        offset_adjust;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] drop_count;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int last_sample_edge = 0;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] ts;
    logic [15:0] data;
  } rec_t;

  rec_t mq[$];
  rec_t cur;
  rec_t new_rec;
  bit   in_flight = 0;
  int   pos = 0;
  bit   m_adj = 0;
  bit   m_ovf = 0;
  int   m_drop = 0;
  bit   model_reset = 1;
  bit   mdl_full, mdl_beat, mdl_done;

  logic [7:0] got[$];
  bit         glast[$];
  int         gedge[$];

  timestamp_framer #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_128M        (clk_128M),
    .rst_n           (rst_n),
    .timestamp_count (timestamp_count),
    .offset_adjust   (offset_adjust),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .drop_count      (drop_count)
  );

  always #4 clk_128M = ~clk_128M;

  function automatic logic [7:0] exp_byte(input rec_t r, input int p);
    logic [63:0] w;
    w = {8'hA5, r.flags, r.ts, r.data};
    return w[63-8*p -: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Edge counter and log of every byte the host accepts
  always @(posedge clk_128M) begin
    cyc++;
    if (rst_n && m_tvalid && m_tready) begin
      got.push_back(m_tdata);
      glast.push_back(m_tlast);
      gedge.push_back(cyc);
    end
  end

  // Behavioural model: waiting records, one frame in flight, sticky flags, drop count
  always @(posedge clk_128M) begin
    if (!rst_n) begin
      model_reset = 1;
      mq.delete();
      in_flight = 0;
      pos = 0;
      m_adj = 0;
      m_ovf = 0;
      m_drop = 0;
    end else begin
      model_reset = 0;
      mdl_full = (mq.size() == DEPTH);
      mdl_beat = in_flight && m_tready;
      mdl_done = mdl_beat && (pos == 7);
      if (mdl_beat && !mdl_done) pos++;
      if (!in_flight || mdl_done) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          in_flight = 1;
          pos = 0;
        end else begin
          in_flight = 0;
        end
      end
      if (sample_valid && !mdl_full) begin
        new_rec.flags = {6'b0, m_ovf, m_adj | offset_adjust};
        new_rec.ts    = timestamp_count;
        new_rec.data  = sample_data;
        mq.push_back(new_rec);
        m_adj = 0;
        m_ovf = 0;
      end else begin
        if (offset_adjust) m_adj = 1;
        if (sample_valid) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk_128M) begin
    if (model_reset) begin
      checkOutput("reset_tvalid", 32'(m_tvalid), 32'h0);
      checkOutput("reset_tlast", 32'(m_tlast), 32'h0);
      checkOutput("reset_tdata", 32'(m_tdata), 32'h0);
      checkOutput("reset_drop_count", 32'(drop_count), 32'h0);
    end else begin
      checkOutput("model_tvalid", 32'(m_tvalid), 32'(in_flight));
      checkOutput("model_drop_count", 32'(drop_count), 32'(m_drop));
      if (in_flight) begin
        checkOutput("model_tdata", 32'(m_tdata), 32'(exp_byte(cur, pos)));
        checkOutput("model_tlast", 32'(m_tlast), 32'(pos == 7));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] ts, input logic [15:0] d, input bit adj);
    timestamp_count  = ts;
    sample_data      = d;
    sample_valid     = 1'b1;
    offset_adjust    = adj;
    last_sample_edge = cyc + 1;
    @(negedge clk_128M);
    sample_valid  = 1'b0;
    offset_adjust = 1'b0;
  endtask

  task automatic pulseAdjust();
    offset_adjust = 1'b1;
    @(negedge clk_128M);
    offset_adjust = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_128M);
  endtask

  task automatic waitBytes(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk_128M);
      k++;
    end
    checkOutput("bytes_received", 32'(got.size()), 32'(n));
  endtask

  task automatic checkFrame(input string name, input int base, input logic [63:0] exp);
    for (int i = 0; i < 8; i++) begin
      if (base + i < got.size())
        checkOutput(name, 32'(got[base+i]), 32'(exp[63-8*i -: 8]));
      else
        checkOutput(name, 32'hFFFF_FFFF, 32'(exp[63-8*i -: 8]));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    rst_n = 1'b0;
    timestamp_count = '0;
    offset_adjust = 1'b0;
    sample_data = '0;
    sample_valid = 1'b0;
    m_tready = 1'b1;
    idle(3);
    checkOutput("reset_state_tvalid", 32'(m_tvalid), 32'h0);
    rst_n = 1'b1;

    $display("[TB] single sample");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'h0000_00FF, 16'h1234, 1'b0);
    e = last_sample_edge;
    waitBytes(8, 40);
    checkFrame("single_frame", 0, 64'hA500_0000_00FF_1234);
    if (got.size() >= 8) begin
      checkOutput("single_latency", 32'(gedge[0]), 32'(e + 2));
      checkOutput("single_tlast_b6", 32'(glast[6]), 32'h0);
      checkOutput("single_tlast_b7", 32'(glast[7]), 32'h1);
    end

    $display("[TB] stall at byte 3");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'hAABB_CCDD, 16'h5678, 1'b0);
    begin
      int k = 0;
      while (got.size() < 3 && k < 40) begin @(negedge clk_128M); k++; end
    end
    m_tready = 1'b0;
    repeat (5) begin
      @(negedge clk_128M);
      checkOutput("stall_tdata", 32'(m_tdata), 32'hBB);
      checkOutput("stall_tvalid", 32'(m_tvalid), 32'h1);
    end
    m_tready = 1'b1;
    waitBytes(8, 40);
    checkFrame("stall_frame", 0, 64'hA500_AABB_CCDD_5678);

    $display("[TB] overflow");
    got.delete(); glast.delete(); gedge.delete();
    m_tready = 1'b0;
    applyStimulus(32'd100, 16'h0000, 1'b0);
    idle(2);
    for (int i = 1; i <= DEPTH + 2; i++) applyStimulus(32'(100 + i), 16'(i), 1'b0);
    checkOutput("overflow_drop_count", 32'(drop_count), 32'd2);
    m_tready = 1'b1;
    waitBytes(40, 100);
    applyStimulus(32'd200, 16'hBEEF, 1'b0);
    idle(1);
    applyStimulus(32'd201, 16'hCAFE, 1'b0);
    waitBytes(56, 60);
    if (got.size() >= 56) begin
      checkOutput("overflow_first_ts", 32'(got[5]), 32'h64);
      checkOutput("overflow_kept_flags", 32'(got[9]), 32'h00);
      checkOutput("overflow_last_kept_ts", 32'(got[37]), 32'h68);
      checkOutput("overflow_flag_set", 32'(got[41]), 32'h02);
      checkOutput("overflow_flag_clear", 32'(got[49]), 32'h00);
    end

    $display("[TB] offset adjust");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'h0000_1000, 16'h000A, 1'b1);
    idle(1);
    applyStimulus(32'h0000_1001, 16'h000B, 1'b0);
    idle(1);
    pulseAdjust();
    idle(1);
    applyStimulus(32'h0000_1002, 16'h000C, 1'b0);
    waitBytes(24, 80);
    if (got.size() >= 24) begin
      checkOutput("adjust_A_flags", 32'(got[1]), 32'h01);
      checkOutput("adjust_B_flags", 32'(got[9]), 32'h00);
      checkOutput("adjust_C_flags", 32'(got[17]), 32'h01);
    end

    $display("[TB] back-to-back");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'd1000, 16'h0001, 1'b0);
    applyStimulus(32'd1001, 16'h0002, 1'b0);
    applyStimulus(32'd1002, 16'h0003, 1'b0);
    waitBytes(24, 60);
    if (got.size() >= 24) begin
      checkOutput("b2b_contiguous", 32'(gedge[23] - gedge[0]), 32'd23);
      checkFrame("b2b_frame0", 0, 64'hA500_0000_03E8_0001);
      checkOutput("b2b_ts1", 32'(got[13]), 32'hE9);
      checkOutput("b2b_ts2", 32'(got[21]), 32'hEA);
      checkOutput("b2b_tlast_mid", 32'(glast[15]), 32'h1);
    end

    $display("[TB] timestamp wrap");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'hFFFF_FFFF, 16'h00AA, 1'b0);
    applyStimulus(32'h0000_0000, 16'h00BB, 1'b0);
    waitBytes(16, 50);
    checkFrame("wrap_frame0", 0, 64'hA500_FFFF_FFFF_00AA);
    checkFrame("wrap_frame1", 8, 64'hA500_0000_0000_00BB);

    $display("[TB] reset mid-frame");
    got.delete(); glast.delete(); gedge.delete();
    applyStimulus(32'h0000_0055, 16'h4444, 1'b0);
    begin
      int k = 0;
      while (got.size() < 4 && k < 40) begin @(negedge clk_128M); k++; end
    end
    rst_n = 1'b0;
    sample_valid = 1'b1;
    timestamp_count = 32'h0000_0066;
    sample_data = 16'h6666;
    @(negedge clk_128M);
    checkOutput("midreset_tvalid", 32'(m_tvalid), 32'h0);
    checkOutput("midreset_drop_count", 32'(drop_count), 32'h0);
    sample_valid = 1'b0;
    @(negedge clk_128M);
    rst_n = 1'b1;
    got.delete(); glast.delete(); gedge.delete();
    idle(3);
    checkOutput("midreset_no_resume", 32'(got.size()), 32'd0);
    applyStimulus(32'h0000_0077, 16'h9999, 1'b0);
    waitBytes(8, 40);
    checkFrame("midreset_new_frame", 0, 64'hA500_0000_0077_9999);
    idle(5);
    checkOutput("midreset_byte_total", 32'(got.size()), 32'd8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timestamp_framer.md
TIMESTAMP_FRAMER -- requirements
Module: timestamp_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered sample records (power of 2, min 2).
REQ-002 clk_128M  input  1  sole clock, 128 MHz; one clock; reset is synchronous and active-low.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk_128M.
REQ-004 timestamp_count  input  32  DUT-aligned timestamp in 128 MHz counts.
REQ-005 offset_adjust  input  1  single-cycle pulse when the timestamp offset was raised.
REQ-006 sample_data  input  16  decoded sample word from the serial stream.
REQ-007 sample_valid  input  1  one-cycle strobe qualifying sample_data; no backpressure.
REQ-008 m_tdata  output  8  frame byte to host interface.
REQ-009 m_tvalid  output  1  m_tdata valid.
REQ-010 m_tready  input  1  host accepts byte when m_tvalid && m_tready.
REQ-011 m_tlast  output  1  high on final byte of each frame.
REQ-012 drop_count  output  16  saturating count of samples dropped on full FIFO.

Function
REQ-013 On sample_valid with FIFO not full, SHALL push record {flags, timestamp_count, sample_data} sampled in that same cycle.
REQ-014 Full SHALL be judged on the registered occupancy; a push while full is dropped even if a pop occurs in the same cycle.
REQ-015 A dropped sample SHALL increment drop_count (saturating at 16'hFFFF) and set a sticky overflow flag.
REQ-016 offset_adjust SHALL set a sticky adjust flag; a pulse coinciding with an accepted push is included in that record and not carried over.
REQ-017 flags byte = {6'b0, overflow, adjust}; both sticky flags SHALL clear when attached to an accepted record.
REQ-018 Frame is 8 bytes, in order: 8'hA5, flags, ts[31:24], ts[23:16], ts[15:8], ts[7:0], data[15:8], data[7:0].
REQ-019 FSM states: IDLE, SEND; IDLE->SEND when FIFO non-empty (record popped into a frame register); SEND->IDLE after byte 7 accepted if FIFO empty, else SEND restarts at byte 0 with the next record without an idle cycle.
REQ-020 Byte index SHALL advance only on m_tvalid && m_tready; m_tlast SHALL be high when index==7.
REQ-021 While m_tvalid && !m_tready, m_tdata, m_tlast and m_tvalid SHALL remain stable.
REQ-022 Latency: sample_valid at cycle N with empty FIFO and idle FSM -> m_tvalid with 8'hA5 at cycle N+2.
REQ-023 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged and lose no record.
REQ-024 timestamp_count wrap (FFFFFFFF->0) SHALL be passed through unmodified; no interpretation in this block.

Reset
REQ-025 With rst_n low at a clock edge: m_tvalid=0, m_tlast=0, m_tdata=8'h00, drop_count=0, FIFO empty, sticky flags clear, FSM=IDLE.
REQ-026 Reset mid-frame SHALL abort the frame; no partial frame resumes after reset; inputs are ignored during reset.

Structure
REQ-027 Shared package timestamp_pkg SHALL hold SYNC_BYTE (8'hA5), FRAME_BYTES (8), the packed record typedef (8+32+16 bits) and the FSM state enum.
REQ-028 One sub-module, frame_fifo: synchronous FIFO of records with push, pop, full, empty, registered occupancy, same reset.
REQ-029 Implementation SHALL be 120-400 lines total, single clock domain, no latches.

Verification
REQ-030 Single sample 16'h1234 at timestamp 32'h0000_00FF, m_tready=1 -> bytes A5,00,00,00,00,FF,12,34 with m_tlast on the last byte, first byte at N+2.
REQ-031 Stall: m_tready low for 5 cycles mid-frame at byte 3 -> m_tdata holds ts[23:16] stable; the frame completes intact after release.
REQ-032 Overflow: m_tready=0, push FIFO_DEPTH+2 samples -> drop_count=2; the first accepted sample after draining has flags bit1=1; subsequent frames have bit1=0.
REQ-033 offset_adjust pulse in the same cycle as sample A, then sample B -> A flags=01, B flags=00; a pulse between samples -> the next frame has flags=01.
REQ-034 Back-to-back: 3 samples on consecutive cycles, m_tready=1 -> 24 contiguous bytes, m_tvalid never drops, ts values monotonic.
REQ-035 Assert rst_n=0 at byte 4 of a frame -> next cycle m_tvalid=0, drop_count=0; a new sample after reset yields a full frame starting with A5.
